// File: rtl/point_uart_pkg.sv
// rtl/point_uart_pkg.sv - shared state type, packet constants and checksum for the point UART
package point_uart_pkg;

  // IDLE/ARM/LOAD belong to the packet sequencer; START/DATA/STOP to the byte serializer.
  // The packet sequencer reuses DATA to mean "packet bytes are being serialized".
  typedef enum logic [2:0] {IDLE, ARM, LOAD, START, DATA, STOP} state_t;

  localparam int         PKT_BYTES      = 6;
  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  // Sum of the four point bytes, wrapping at 256
  function automatic logic [7:0] pkt_checksum(input logic [15:0] h, input logic [15:0] v);
    pkt_checksum = h[15:8] + h[7:0] + v[15:8] + v[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with valid/ready input and back-to-back bytes
module uart_tx_byte
  import point_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
)(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tdata,
  input  logic       tvalid,
  output logic       tready,
  output logic       tx
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q;
  logic          tx_d;
  logic          baud_last;
  logic          take;

  assign baud_last = (baud_q == BAUD_LAST);
  // Ready in the last stop-bit cycle lets the next start bit follow with no gap
  assign tready    = (state_q == IDLE) || (state_q == STOP && baud_last);
  assign take      = tvalid && tready;

  // State register, baud/bit counters, captured byte and the registered line
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx      <= tx_d;
      if (take) begin
        data_q <= tdata;
        baud_q <= '0;
      end else if (state_q != IDLE) begin
        baud_q <= baud_last ? '0 : baud_q + 1'b1;
      end
    end
  end

  // Next-state: start bit, eight data bits, stop bit, then next byte or idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tvalid) state_d = START;
      START:   if (baud_last) state_d = DATA;
      DATA:    if (baud_last && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_last) state_d = tvalid ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: next bit index and the line level for the coming cycle
  always_comb begin
    bit_d = bit_q;
    if (take)
      bit_d = '0;
    else if (state_q == DATA && baud_last)
      bit_d = bit_q + 3'd1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/point_uart_tx.sv
// rtl/point_uart_tx.sv - sends each frame's median point to the host as a 6-byte UART packet
module point_uart_tx
  import point_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VGA_VS,
  input  logic [15:0] BINARY_POINTS_H,
  input  logic [15:0] BINARY_POINTS_V,
  output logic        UART_TX,
  output logic        TX_BUSY,
  output logic [7:0]  DROP_CNT
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

  state_t      state_q, state_d;
  logic        r_vs;
  logic        vs_rise;
  logic [2:0]  byte_idx;
  logic [15:0] h_q, v_q;
  logic [7:0]  drop_q;
  logic [7:0]  byte_tdata;
  logic        byte_tvalid;
  logic        byte_tready;

  assign vs_rise  = VGA_VS && !r_vs;
  assign TX_BUSY  = (state_q != IDLE);
  assign DROP_CNT = drop_q;

  // VS delay flop follows the input even in reset so reset release never fakes a rise
  always_ff @(posedge CLK) begin
    r_vs <= VGA_VS;
  end

  // State register, point latch, byte index and saturating drop counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      byte_idx <= '0;
      h_q      <= '0;
      v_q      <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD) begin
        h_q      <= BINARY_POINTS_H;
        v_q      <= BINARY_POINTS_V;
        byte_idx <= '0;
      end else if (state_q == DATA && byte_tvalid && byte_tready) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (vs_rise && state_q != IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  // Next-state: wait a cycle for the point to settle, latch it, then stream the packet
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vs_rise) state_d = ARM;
      ARM:     state_d = LOAD;
      LOAD:    if (byte_tready) state_d = DATA;
      DATA:    if (byte_idx == LAST_IDX && byte_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte mux: header during LOAD, then the byte after the one being serialized
  always_comb begin
    byte_tvalid = (state_q == LOAD) || (state_q == DATA && byte_idx != LAST_IDX);
    byte_tdata  = HEADER;
    if (state_q == DATA) begin
      case (byte_idx)
        3'd0:    byte_tdata = h_q[15:8];
        3'd1:    byte_tdata = h_q[7:0];
        3'd2:    byte_tdata = v_q[15:8];
        3'd3:    byte_tdata = v_q[7:0];
        default: byte_tdata = pkt_checksum(h_q, v_q);
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .CLK    (CLK),
    .RESET  (RESET),
    .tdata  (byte_tdata),
    .tvalid (byte_tvalid),
    .tready (byte_tready),
    .tx     (UART_TX)
  );

endmodule

// File: tb/tb_point_uart_tx.sv
// tb/tb_point_uart_tx.sv - randomized scoreboard bench for point_uart_tx
module tb_point_uart_tx;

  localparam int CPB      = 4;
  localparam int PERIOD   = 10;
  localparam int BUSY_CYC = 2 + 60 * CPB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        VGA_VS = 1'b0;
  logic [15:0] BINARY_POINTS_H = '0;
  logic [15:0] BINARY_POINTS_V = '0;
  logic        UART_TX;
  logic        TX_BUSY;
  logic [7:0]  DROP_CNT;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  time        last_acc = 0;
  bit         have_acc = 0;
  int         exp_drop = 0;
  bit         mon_ok;

  always #(PERIOD / 2) CLK = ~CLK;

  point_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .HEADER       (8'hAA)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .VGA_VS          (VGA_VS),
    .BINARY_POINTS_H (BINARY_POINTS_H),
    .BINARY_POINTS_V (BINARY_POINTS_V),
    .UART_TX         (UART_TX),
    .TX_BUSY         (TX_BUSY),
    .DROP_CNT        (DROP_CNT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a rise is taken only if the previous accepted packet's busy window
  // (2 + 60*CPB cycles) has fully elapsed; the edge where busy falls still drops.
  task automatic model_rise(input logic [15:0] h, input logic [15:0] v);
    int s;
    if (!have_acc || ($time - last_acc) >= time'((BUSY_CYC + 1) * PERIOD)) begin
      have_acc = 1;
      last_acc = $time;
      s = h / 256 + h % 256 + v / 256 + v % 256;
      sb_q.push_back(8'hAA);
      sb_q.push_back(8'(h / 256));
      sb_q.push_back(8'(h % 256));
      sb_q.push_back(8'(v / 256));
      sb_q.push_back(8'(v % 256));
      sb_q.push_back(8'(s % 256));
    end else if (exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  // One VS rise; the point is held until after the DUT has latched it
  task automatic rise(input logic [15:0] h, input logic [15:0] v);
    @(negedge CLK);
    VGA_VS = 1'b1;
    BINARY_POINTS_H = h;
    BINARY_POINTS_V = v;
    @(posedge CLK);
    model_rise(h, v);
    @(negedge CLK);
    VGA_VS = 1'b0;
    @(negedge CLK);
  endtask

  // Rise from idle, measuring start-bit latency and busy duration in samples after the detect edge
  task automatic send_measured(input logic [15:0] h, input logic [15:0] v);
    int n;
    int first_low;
    int busy_n;
    @(negedge CLK);
    VGA_VS = 1'b1;
    BINARY_POINTS_H = h;
    BINARY_POINTS_V = v;
    @(posedge CLK);
    model_rise(h, v);
    n = 0;
    first_low = 0;
    busy_n = 0;
    while (n < 2000) begin
      @(negedge CLK);
      n++;
      if (n == 1) VGA_VS = 1'b0;
      if (first_low == 0 && UART_TX === 1'b0) first_low = n;
      if (TX_BUSY === 1'b1) busy_n++;
      else break;
    end
    // start bit drives low from the second edge after detect, seen at the third sample
    check("start_latency", first_low, 3);
    check("busy_cycles", busy_n, BUSY_CYC);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((TX_BUSY !== 1'b0 || sb_q.size() != 0) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0b pending=%0d expected idle with none pending", TX_BUSY, sb_q.size());
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (RESET) mon_ok = 0;
    end
  endtask

  // Monitor: decodes each 8N1 byte at mid-bit and compares with the scoreboard head
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] exp;
    logic       sbit;
    logic       pbit;
    forever begin
      @(negedge CLK);
      if (!RESET && UART_TX === 1'b0) begin
        mon_ok = 1;
        mon_wait(CPB / 2);
        sbit = UART_TX;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          b[i] = UART_TX;
        end
        mon_wait(CPB);
        pbit = UART_TX;
        if (mon_ok) begin
          check("framing", {30'd0, sbit, pbit}, 32'd1);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h expected no byte", b);
          end else begin
            exp = sb_q.pop_front();
            check("byte", b, exp);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge CLK);
    check("reset_tx", UART_TX, 1);
    check("reset_busy", TX_BUSY, 0);
    check("reset_drop", DROP_CNT, 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    send_measured(16'h0140, 16'h00F0);
    wait_idle();
    send_measured(16'h0000, 16'h0000);
    wait_idle();
    send_measured(16'hFFFF, 16'hFF01);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      rise(16'($urandom), 16'($urandom));
      wait_idle();
    end

    rise(16'($urandom), 16'($urandom));
    repeat (47) @(negedge CLK);
    rise(16'($urandom), 16'($urandom));
    repeat (47) @(negedge CLK);
    rise(16'($urandom), 16'($urandom));
    wait_idle();
    check("drop_three", DROP_CNT, exp_drop);

    rise(16'($urandom), 16'($urandom));
    repeat (239) @(negedge CLK);
    rise(16'($urandom), 16'($urandom));
    rise(16'($urandom), 16'($urandom));
    wait_idle();
    check("drop_boundary", DROP_CNT, exp_drop);

    for (int i = 0; i < 300; i++) rise(16'($urandom), 16'($urandom));
    wait_idle();
    check("drop_saturate", DROP_CNT, exp_drop);

    rise(16'($urandom), 16'($urandom));
    repeat (135) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_tx", UART_TX, 1);
    check("abort_busy", TX_BUSY, 0);
    check("abort_drop", DROP_CNT, 0);
    @(negedge CLK);
    RESET = 1'b0;
    sb_q.delete();
    have_acc = 0;
    exp_drop = 0;
    repeat (50) @(negedge CLK);
    send_measured(16'($urandom), 16'($urandom));
    wait_idle();
    check("final_drop", DROP_CNT, exp_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
